// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, FSM states
// and the position of the valid flag in the ACTIVE register.
package irq_ctrl_pkg;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_TYPE    = 2'd2;
  localparam logic [1:0] ADDR_ACTIVE  = 2'd3;

  localparam int ACTIVE_VALID_BIT = 31;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  typedef enum logic [1:0] {
    IRQ_IDLE   = ST_IDLE,
    IRQ_ASSERT = ST_ASSERT,
    IRQ_GAP    = ST_GAP
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: reports whether any bit is set and
// the index of the least significant set bit.
module irq_prio_enc #(
  parameter int W    = 32,
  parameter int ID_W = 5
) (
  input  logic [W-1:0]    vec,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scanning from the top down lets the last hit (lowest index) win.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending/enable/type registers, a one-hot irq line
// sequencer (IDLE -> ASSERT -> GAP) and a simple request/grant register port.
// Optional feature: define IRQ_CTRL_EDGE_EN for per-source edge detection and TYPE.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 32,
  parameter int ID_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic              reg_req_i,
  input  logic              reg_we_i,
  input  logic [1:0]        reg_addr_i,
  input  logic [31:0]       reg_wdata_i,
  output logic              reg_gnt_o,
  output logic              reg_rvalid_o,
  output logic [31:0]       reg_rdata_o,
  output logic [31:0]       irq_o,
  input  logic              irq_ack_i,
  input  logic [ID_W-1:0]   irq_id_i
);

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] pend_en;
  logic [NUM_SRC-1:0] act_mask;
  logic [ID_W-1:0]    active_id_q;
  logic [ID_W-1:0]    enc_id;
  logic               enc_valid;
  logic               wr_en;
  logic               rd_en;
  logic               ack_hit;
  logic               active_live;
  irq_state_e         state_q;
  irq_state_e         state_d;
  logic               rvalid_q;
  logic [31:0]        rdata_q;
  logic [31:0]        rd_mux;

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] src_qq;
  logic [NUM_SRC-1:0] type_q;
  logic [NUM_SRC-1:0] clr_mask;
  logic [NUM_SRC-1:0] edge_next;
`endif

  assign reg_gnt_o = reg_req_i;
  assign wr_en     = reg_req_i & reg_we_i;
  assign rd_en     = reg_req_i & ~reg_we_i;
  assign pend_en   = pending_q & enable_q;

  irq_prio_enc #(
    .W    (NUM_SRC),
    .ID_W (ID_W)
  ) u_prio_enc (
    .vec   (pend_en),
    .valid (enc_valid),
    .id    (enc_id)
  );

  always_comb begin
    act_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      act_mask[i] = (active_id_q == ID_W'(i));
    end
  end

  assign active_live = |(pend_en & act_mask);
  assign ack_hit     = (state_q == IRQ_ASSERT) && irq_ack_i && (irq_id_i == active_id_q);

`ifdef IRQ_CTRL_EDGE_EN
  // Edge sources: a new rising edge beats any clear landing on the same edge.
  always_comb begin
    clr_mask = '0;
    if (wr_en && (reg_addr_i == ADDR_PENDING)) begin
      clr_mask = reg_wdata_i[NUM_SRC-1:0];
    end
    if (ack_hit) begin
      clr_mask = clr_mask | act_mask;
    end
    edge_next = (pending_q & ~clr_mask) | (src_q & ~src_qq);
    pending_d = (type_q & edge_next) | (~type_q & src_q);
  end
`else
  assign pending_d = src_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE: begin
        if (enc_valid) begin
          state_d = IRQ_ASSERT;
        end
      end
      IRQ_ASSERT: begin
        if (ack_hit) begin
          state_d = IRQ_GAP;
        end else if (!active_live) begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_GAP:  state_d = IRQ_IDLE;
      default:  state_d = IRQ_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr_i)
      ADDR_PENDING: rd_mux[NUM_SRC-1:0] = pending_q;
      ADDR_ENABLE:  rd_mux[NUM_SRC-1:0] = enable_q;
      ADDR_TYPE: begin
`ifdef IRQ_CTRL_EDGE_EN
        rd_mux[NUM_SRC-1:0] = type_q;
`endif
      end
      ADDR_ACTIVE: begin
        if (state_q == IRQ_ASSERT) begin
          rd_mux[ACTIVE_VALID_BIT] = 1'b1;
          rd_mux[ID_W-1:0]         = active_id_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q       <= '0;
      pending_q   <= '0;
      state_q     <= IRQ_IDLE;
      active_id_q <= '0;
    end else begin
      src_q     <= src_i;
      pending_q <= pending_d;
      state_q   <= state_d;
      if ((state_q == IRQ_IDLE) && enc_valid) begin
        active_id_q <= enc_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= '0;
    end else if (wr_en && (reg_addr_i == ADDR_ENABLE)) begin
      enable_q <= reg_wdata_i[NUM_SRC-1:0];
    end
  end

`ifdef IRQ_CTRL_EDGE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      src_qq <= '0;
      type_q <= '0;
    end else begin
      src_qq <= src_q;
      if (wr_en && (reg_addr_i == ADDR_TYPE)) begin
        type_q <= reg_wdata_i[NUM_SRC-1:0];
      end
    end
  end
`endif

  // Read data is captured at the request edge and shown for one cycle only.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_en;
      rdata_q  <= rd_en ? rd_mux : 32'h0;
    end
  end

  assign reg_rvalid_o = rvalid_q & ~rst;
  assign reg_rdata_o  = rst ? 32'h0 : rdata_q;

  always_comb begin
    irq_o = '0;
    if (!rst && (state_q == IRQ_ASSERT)) begin
      irq_o[NUM_SRC-1:0] = act_mask;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios followed by random
// traffic, all checked against a behavioural model of the controller.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_i;
  logic        reg_req_i;
  logic        reg_we_i;
  logic [1:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic        reg_gnt_o;
  logic        reg_rvalid_o;
  logic [31:0] reg_rdata_o;
  logic [31:0] irq_o;
  logic        irq_ack_i;
  logic [4:0]  irq_id_i;

  int total = 0;
  int bad   = 0;

  bit [31:0]   m_pend, m_en, m_type, m_src1, m_src2;
  int          m_active;
  bit          m_gap;
  logic [31:0] exp_irq;
  logic        exp_rvalid;
  logic [31:0] exp_rdata;

  irq_ctrl #(
    .NUM_SRC (32),
    .ID_W    (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_i        (src_i),
    .reg_req_i    (reg_req_i),
    .reg_we_i     (reg_we_i),
    .reg_addr_i   (reg_addr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_gnt_o    (reg_gnt_o),
    .reg_rvalid_o (reg_rvalid_o),
    .reg_rdata_o  (reg_rdata_o),
    .irq_o        (irq_o),
    .irq_ack_i    (irq_ack_i),
    .irq_id_i     (irq_id_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] read_model(input logic [1:0] a);
    case (a)
      2'd0:    return m_pend;
      2'd1:    return m_en;
      2'd2:    return EDGE_EN ? m_type : 32'h0;
      default: return (m_active >= 0) ? (32'h8000_0000 | 32'(m_active)) : 32'h0;
    endcase
  endfunction

  // Advance the reference model across one rising edge using the inputs
  // that were presented to the DUT just before that edge.
  task automatic modelEdge();
    bit [31:0] next_pend;
    bit        ack_hit;
    bit        rose, cleared;
    if (rst) begin
      m_pend = 0; m_en = 0; m_type = 0; m_src1 = 0; m_src2 = 0;
      m_active = -1; m_gap = 0;
      exp_rvalid = 1'b0; exp_rdata = 32'h0;
    end else begin
      exp_rvalid = reg_req_i && !reg_we_i;
      exp_rdata  = exp_rvalid ? read_model(reg_addr_i) : 32'h0;
      ack_hit = (m_active >= 0) && irq_ack_i && (int'(irq_id_i) == m_active);
      for (int i = 0; i < 32; i++) begin
        if (EDGE_EN && m_type[i]) begin
          rose    = m_src1[i] && !m_src2[i];
          cleared = (reg_req_i && reg_we_i && reg_addr_i == 2'd0 && reg_wdata_i[i]) ||
                    (ack_hit && i == m_active);
          next_pend[i] = rose || (m_pend[i] && !cleared);
        end else begin
          next_pend[i] = m_src1[i];
        end
      end
      if (m_gap) begin
        m_gap = 0;
      end else if (m_active < 0) begin
        for (int i = 31; i >= 0; i--) begin
          if (m_pend[i] && m_en[i]) m_active = i;
        end
      end else if (ack_hit) begin
        m_active = -1;
        m_gap    = 1;
      end else if (!(m_pend[m_active] && m_en[m_active])) begin
        m_active = -1;
      end
      if (reg_req_i && reg_we_i && reg_addr_i == 2'd1) m_en = reg_wdata_i;
      if (reg_req_i && reg_we_i && reg_addr_i == 2'd2 && EDGE_EN) m_type = reg_wdata_i;
      m_pend = next_pend;
      m_src2 = m_src1;
      m_src1 = src_i;
    end
    exp_irq = (m_active >= 0) ? (32'h1 << m_active) : 32'h0;
  endtask

  task automatic checkOutput(input string tag);
    total++;
    assert (irq_o === exp_irq) else begin
      bad++;
      $error("[TB] FAIL %s irq_o observed=%h expected=%h", tag, irq_o, exp_irq);
    end
    total++;
    assert (reg_rvalid_o === exp_rvalid) else begin
      bad++;
      $error("[TB] FAIL %s rvalid observed=%b expected=%b", tag, reg_rvalid_o, exp_rvalid);
    end
    total++;
    assert (reg_rdata_o === exp_rdata) else begin
      bad++;
      $error("[TB] FAIL %s rdata observed=%h expected=%h", tag, reg_rdata_o, exp_rdata);
    end
    total++;
    assert (reg_gnt_o === reg_req_i) else begin
      bad++;
      $error("[TB] FAIL %s gnt observed=%b expected=%b", tag, reg_gnt_o, reg_req_i);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] s, input logic rq,
                               input logic w, input logic [1:0] a, input logic [31:0] d,
                               input logic ak, input logic [4:0] id, input string tag);
    rst = r; src_i = s; reg_req_i = rq; reg_we_i = w; reg_addr_i = a;
    reg_wdata_i = d; irq_ack_i = ak; irq_id_i = id;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, src_i, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 5'd0, tag);
  endtask

  task automatic setSrc(input logic [31:0] s, input string tag);
    applyStimulus(1'b0, s, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 5'd0, tag);
  endtask

  task automatic regWrite(input logic [1:0] a, input logic [31:0] d);
    applyStimulus(1'b0, src_i, 1'b1, 1'b1, a, d, 1'b0, 5'd0, "reg_write");
  endtask

  task automatic regRead(input logic [1:0] a, input logic [31:0] want, input string tag);
    applyStimulus(1'b0, src_i, 1'b1, 1'b0, a, 32'h0, 1'b0, 5'd0, tag);
    checkValue(tag, reg_rdata_o, want);
  endtask

  task automatic ackId(input logic [4:0] id, input string tag);
    applyStimulus(1'b0, src_i, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, id, tag);
  endtask

  task automatic waitIrq(input logic [31:0] want, input int budget, input string tag);
    int n = 0;
    while (irq_o !== want && n < budget) begin
      idle(1, tag);
      n++;
    end
    checkValue(tag, irq_o, want);
  endtask

  initial begin
    logic [31:0] rs;
    logic [4:0]  rid;
    m_active = -1;
    $display("[TB] start, edge feature %0d", EDGE_EN);

    rst = 1'b1; src_i = 0; reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = 2'd1;
    reg_wdata_i = 0; irq_ack_i = 1'b0; irq_id_i = 0;
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 2'd1, 32'h0, 1'b0, 5'd0, "reset_a");
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 5'd0, "reset_b");
    checkValue("reset_irq", irq_o, 32'h0);
    idle(1, "post_reset");

    // Level sources 4 and 5, lowest index wins and re-asserts after GAP.
    regWrite(2'd1, 32'hFFFF_FFFF);
    regRead(2'd1, 32'hFFFF_FFFF, "enable_rb");
    setSrc(32'h0000_0030, "level_src");
    waitIrq(32'h10, 8, "level_irq4");
    regRead(2'd3, 32'h8000_0004, "active_rb");
    ackId(5'd4, "ack4");
    checkValue("gap_irq", irq_o, 32'h0);
    waitIrq(32'h10, 6, "level_reassert");
    setSrc(32'h0000_0020, "drop_src4");
    waitIrq(32'h20, 8, "level_irq5");

    // No preemption by a higher-priority arrival; wrong-ID ack ignored.
    setSrc(32'h0000_0022, "raise_src1");
    idle(4, "hold_irq5");
    checkValue("no_preempt", irq_o, 32'h20);
    ackId(5'd3, "ack_wrong");
    checkValue("wrong_ack_irq", irq_o, 32'h20);
    regRead(2'd0, 32'h0000_0022, "pending_rb");
    ackId(5'd5, "ack5");
    checkValue("ack5_gap", irq_o, 32'h0);
    waitIrq(32'h2, 6, "next_irq1");

    // Reset in the middle of an assertion.
    applyStimulus(1'b1, src_i, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 5'd0, "mid_reset");
    checkValue("mid_reset_irq", irq_o, 32'h0);
    regRead(2'd1, 32'h0, "enable_after_rst");
    regWrite(2'd2, 32'hFFFF_FFFF);
    regRead(2'd2, EDGE_EN ? 32'hFFFF_FFFF : 32'h0, "type_rb");
    idle(3, "settle");

`ifdef IRQ_CTRL_EDGE_EN
    // Single-cycle pulse on an edge source, then acknowledge clears it.
    setSrc(32'h0, "edge_quiet");
    idle(3, "edge_quiet");
    regWrite(2'd2, 32'h1);
    regWrite(2'd0, 32'hFFFF_FFFF);
    regWrite(2'd1, 32'h1);
    setSrc(32'h1, "pulse");
    setSrc(32'h0, "pulse_end");
    waitIrq(32'h1, 4, "edge_irq0");
    ackId(5'd0, "ack0");
    checkValue("edge_gap", irq_o, 32'h0);
    idle(1, "edge_after_gap");
    checkValue("edge_no_reassert", irq_o, 32'h0);
    regRead(2'd0, 32'h0, "edge_pending_clr");

    // Set beats write-1-to-clear on the same edge.
    regWrite(2'd1, 32'h0);
    setSrc(32'h1, "pulse2");
    setSrc(32'h0, "pulse2_end");
    idle(1, "pend_set");
    setSrc(32'h1, "edge3");
    applyStimulus(1'b0, 32'h1, 1'b1, 1'b1, 2'd0, 32'h1, 1'b0, 5'd0, "w1c_vs_set");
    regRead(2'd0, 32'h1, "set_wins");
    regWrite(2'd0, 32'h1);
    regRead(2'd0, 32'h0, "w1c_alone");
`endif

    // Random traffic against the model.
    regWrite(2'd1, 32'hFFFF_FFFF);
    for (int n = 0; n < 400; n++) begin
      rs = src_i;
      if ($urandom_range(0, 3) == 0) rs = rs ^ ($urandom & $urandom & $urandom);
      rid = (m_active >= 0 && $urandom_range(0, 1) == 1) ? 5'(m_active) : 5'($urandom);
      applyStimulus(($urandom_range(0, 99) == 0), rs, ($urandom_range(0, 2) == 0),
                    $urandom_range(0, 1) == 1, 2'($urandom), $urandom | $urandom,
                    ($urandom_range(0, 3) == 0), rid, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 32: number of interrupt sources, range 1..32.
REQ-002 SHALL have parameter ID_W, default 5: width of the interrupt ID, equal to clog2(NUM_SRC), minimum 1.
REQ-003 SHALL have port clk  in  1  clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port src_i  in  NUM_SRC  raw interrupt sources, already synchronous to clk.
REQ-006 SHALL have port reg_req_i  in  1  register access request.
REQ-007 SHALL have port reg_we_i  in  1  write enable (1 = write, 0 = read).
REQ-008 SHALL have port reg_addr_i  in  2  word address.
REQ-009 SHALL have port reg_wdata_i  in  32  write data.
REQ-010 SHALL have port reg_gnt_o  out  1  request granted.
REQ-011 SHALL have port reg_rvalid_o  out  1  read data valid.
REQ-012 SHALL have port reg_rdata_o  out  32  read data.
REQ-013 SHALL have port irq_o  out  32  one-hot interrupt lines to the core irq_i; bits NUM_SRC..31 are tied to 0.
REQ-014 SHALL have port irq_ack_i  in  1  core acknowledge strobe.
REQ-015 SHALL have port irq_id_i  in  ID_W  ID being acknowledged.

Function
REQ-016 SHALL drive reg_gnt_o combinationally equal to reg_req_i; every request is granted in the same cycle.
REQ-017 SHALL apply a granted write at that clock edge.
REQ-018 SHALL assert reg_rvalid_o for exactly the one cycle after a granted read, with reg_rdata_o valid in that cycle; reg_rdata_o SHALL be 0 otherwise.
REQ-019 SHALL implement this register map: 0 PENDING (read-only, write-1-to-clear); 1 ENABLE (read/write); 2 TYPE (read/write, 1 = edge, 0 = level); 3 ACTIVE (read-only, bit31 = valid, bits ID_W-1:0 = ID of the asserted interrupt).
REQ-020 SHALL treat unused upper bits as read-zero and write-ignored; writes to read-only bits SHALL be ignored.
REQ-021 SHALL set an edge source's pending bit on a registered 0->1 transition of src_i; that bit SHALL clear only on write-1-to-clear or on acknowledge.
REQ-022 SHALL make a level source's pending bit equal to the registered src_i; write-1-to-clear and acknowledge SHALL have no effect on it.
REQ-023 SHALL give set priority over clear when both hit the same bit at the same edge.
REQ-024 SHALL implement FSM IDLE -> ASSERT -> GAP -> IDLE.
REQ-025 In IDLE, when any pending&enable bit is set, SHALL latch the lowest-index such bit as the active ID and enter ASSERT.
REQ-026 In ASSERT, SHALL hold irq_o one-hot at the active ID, stable.
REQ-027 On irq_ack_i with irq_id_i equal to the active ID, SHALL clear that pending bit (edge sources only) and enter GAP.
REQ-028 In ASSERT, SHALL ignore irq_ack_i with a mismatched ID.
REQ-029 In ASSERT, if the active bit's pending or enable drops, SHALL withdraw (irq_o = 0) and go to IDLE.
REQ-030 GAP SHALL last exactly 1 cycle with irq_o = 0, then go to IDLE.
REQ-031 SHALL drive irq_o = 0 in IDLE and GAP.
REQ-032 Latency: a src_i rising edge sampled at edge N SHALL set pending at N+1 and assert irq_o at N+2.
REQ-033 A higher-priority source arriving during ASSERT SHALL NOT preempt the active ID.

Reset
REQ-034 While rst = 1, SHALL clear PENDING, ENABLE, TYPE and the src_i history register to 0, and set the FSM to IDLE.
REQ-035 While rst = 1, SHALL hold irq_o = 0, reg_rvalid_o = 0 and reg_rdata_o = 0; reg_gnt_o SHALL still follow reg_req_i.
REQ-036 Reset mid-ASSERT SHALL drop irq_o at the next edge, and no acknowledge SHALL be required afterward.

Configuration
REQ-037 With macro IRQ_CTRL_EDGE_EN defined, the TYPE register and edge detection SHALL be implemented as specified above.
REQ-038 Without IRQ_CTRL_EDGE_EN, all sources SHALL be level, TYPE SHALL read 0 and ignore writes, and write-1-to-clear SHALL have no effect.

Structure
REQ-039 Package irq_ctrl_pkg SHALL hold the register address constants, the FSM state enum and the ACTIVE valid-bit index.
REQ-040 The lowest-index priority encoder SHALL be sub-module irq_prio_enc (input vector, output valid and ID).

Verification
REQ-041 Enable=0x1, type=0x1, pulse src_i[0] 1 cycle -> irq_o=0x1 two edges later; ack with ID 0 -> irq_o=0 for 1 cycle, and PENDING reads 0.
REQ-042 Enable=0xFFFFFFFF, src_i=0x00000030 level -> irq_o=0x10 and ACTIVE reads 0x80000004; ack, then GAP -> irq_o=0x10 again while the level is held; drop src_i[4] -> irq_o=0x20.
REQ-043 During ASSERT of ID 5, raise src_i[1] -> irq_o stays 0x20 until ack ID 5; after GAP -> irq_o=0x2.
REQ-044 Ack with irq_id_i=3 while ID 5 is active -> no change to irq_o or PENDING.
REQ-045 Edge source pending, write 0x1 to PENDING on the same cycle as a new edge -> PENDING bit remains 1.
REQ-046 Assert rst during ASSERT -> irq_o=0 next edge; ENABLE reads 0 afterward; without IRQ_CTRL_EDGE_EN, TYPE reads 0 after a write of 0xFFFFFFFF.
